// File: rtl/alu_shift_regfile_if.sv
// Bus bundle for the execution core: regfile, shifter, ALU and status signals.
// master drives operands/controls, slave (the core) returns results and flags.
interface alu_shift_regfile_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
);
  localparam int AW = $clog2(NREGS);

  logic [WIDTH-1:0] data_in;
  logic [AW-1:0]    writenum;
  logic             write;
  logic [AW-1:0]    readnum;
  logic [WIDTH-1:0] data_out;

  logic [WIDTH-1:0] shift_in;
  logic [1:0]       shift;
  logic [WIDTH-1:0] sout;

  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic [1:0]       ALUop;
  logic [WIDTH-1:0] alu_out;
  logic             Z;
  logic             N;
  logic             V;

  logic             loads;
  logic             Z_out;
  logic             N_out;
  logic             V_out;

  modport master (
    output data_in, writenum, write, readnum,
    output shift_in, shift,
    output ain, bin, ALUop, loads,
    input  data_out, sout, alu_out,
    input  Z, N, V, Z_out, N_out, V_out
  );

  modport slave (
    input  data_in, writenum, write, readnum,
    input  shift_in, shift,
    input  ain, bin, ALUop, loads,
    output data_out, sout, alu_out,
    output Z, N, V, Z_out, N_out, V_out
  );
endinterface

// File: rtl/alu_shift_regfile.sv
// Execution core: 8-entry regfile, 1-bit shifter, 4-op ALU, Z/N/V status reg.
// Optional RF_BYPASS_EN: write-through read when readnum==writenum.
module alu_shift_regfile #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input logic                clk,
  input logic                rst_n,
  alu_shift_regfile_if.slave bus
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    SH_PASS = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } sh_op_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_NOT = 2'b11
  } alu_op_e;

  logic [WIDTH-1:0] r_rf [NREGS];
  logic [WIDTH-1:0] w_rd;
  logic [WIDTH-1:0] w_sout;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_alu;
  logic             w_v;
  logic             r_z;
  logic             r_n;
  logic             r_v;
  sh_op_e           w_shop;
  alu_op_e          w_aluop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        r_rf[i] <= '0;
    end else if (bus.write) begin
      r_rf[bus.writenum] <= bus.data_in;
    end
  end

`ifdef RF_BYPASS_EN
  assign w_rd = (bus.write && (bus.readnum == bus.writenum))
              ? bus.data_in
              : r_rf[bus.readnum];
`else
  assign w_rd = r_rf[bus.readnum];
`endif

  assign w_shop = sh_op_e'(bus.shift);

  always_comb begin
    w_sout = bus.shift_in;
    unique case (w_shop)
      SH_PASS: w_sout = bus.shift_in;
      SH_LSL:  w_sout = {bus.shift_in[MSB-1:0], 1'b0};
      SH_LSR:  w_sout = {1'b0, bus.shift_in[MSB:1]};
      SH_ASR:  w_sout = {bus.shift_in[MSB], bus.shift_in[MSB:1]};
    endcase
  end

  assign w_sum   = bus.ain + bus.bin;
  assign w_diff  = bus.ain - bus.bin;
  assign w_aluop = alu_op_e'(bus.ALUop);

  // Overflow is judged on sign bits only; carry-out is never kept.
  always_comb begin
    w_alu = '0;
    w_v   = 1'b0;
    unique case (w_aluop)
      OP_ADD: begin
        w_alu = w_sum;
        w_v   = (bus.ain[MSB] == bus.bin[MSB]) &&
                (w_sum[MSB] != bus.ain[MSB]);
      end
      OP_SUB: begin
        w_alu = w_diff;
        w_v   = (bus.ain[MSB] != bus.bin[MSB]) &&
                (w_diff[MSB] != bus.ain[MSB]);
      end
      OP_AND: w_alu = bus.ain & bus.bin;
      OP_NOT: w_alu = ~bus.bin;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z <= 1'b0;
      r_n <= 1'b0;
      r_v <= 1'b0;
    end else if (bus.loads) begin
      r_z <= (w_alu == '0);
      r_n <= w_alu[MSB];
      r_v <= w_v;
    end
  end

  assign bus.data_out = w_rd;
  assign bus.sout     = w_sout;
  assign bus.alu_out  = w_alu;
  assign bus.Z        = (w_alu == '0);
  assign bus.N        = w_alu[MSB];
  assign bus.V        = w_v;
  assign bus.Z_out    = r_z;
  assign bus.N_out    = r_n;
  assign bus.V_out    = r_v;

endmodule

// File: tb/tb_alu_shift_regfile.sv
// Directed bench for alu_shift_regfile: table of combinational vectors
// plus hand sequences for regfile, status register and async reset.
module tb_alu_shift_regfile;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  alu_shift_regfile_if #(.WIDTH(16), .NREGS(8)) bus ();

  alu_shift_regfile #(.WIDTH(16), .NREGS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] shift_in;
    logic [1:0]  shift;
    logic [15:0] ain;
    logic [15:0] bin;
    logic [1:0]  op;
    logic [15:0] e_sout;
    logic [15:0] e_alu;
    logic        e_z;
    logic        e_n;
    logic        e_v;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [2:0] a, logic [15:0] d);
    bus.write    = 1'b1;
    bus.writenum = a;
    bus.data_in  = d;
    step();
    bus.write    = 1'b0;
  endtask

  task automatic rd(string name, logic [2:0] a, logic [15:0] exp);
    bus.readnum = a;
    #1;
    chk(name, bus.data_out, exp);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;

    vecs[0] = '{16'hF0F1, 2'b00, 16'h7FFF, 16'h0001, 2'b00,
                16'hF0F1, 16'h8000, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{16'hF0F1, 2'b01, 16'h8000, 16'h0001, 2'b01,
                16'hE1E2, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{16'hF0F1, 2'b10, 16'h0005, 16'h0005, 2'b01,
                16'h7878, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{16'hF0F1, 2'b11, 16'hF0F0, 16'h0FF0, 2'b10,
                16'hF878, 16'h00F0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h0001, 2'b11, 16'h1234, 16'h0000, 2'b11,
                16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'h8001, 2'b01, 16'h8000, 16'h8000, 2'b00,
                16'h0002, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{16'h7FFF, 2'b11, 16'h0001, 16'h8000, 2'b01,
                16'h3FFF, 16'h8001, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{16'h8000, 2'b10, 16'hFFFF, 16'h0001, 2'b00,
                16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{16'h0000, 2'b01, 16'h8000, 16'h8000, 2'b10,
                16'h0000, 16'h8000, 1'b0, 1'b1, 1'b0};

    rst_n        = 1'b0;
    bus.data_in  = '0;
    bus.writenum = '0;
    bus.write    = 1'b0;
    bus.readnum  = '0;
    bus.shift_in = '0;
    bus.shift    = '0;
    bus.ain      = '0;
    bus.bin      = '0;
    bus.ALUop    = '0;
    bus.loads    = 1'b0;

    #2;
    rd("rst_r0", 3'd0, 16'h0000);
    chk("rst_zout", {15'd0, bus.Z_out}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      bus.shift_in = vecs[i].shift_in;
      bus.shift    = vecs[i].shift;
      bus.ain      = vecs[i].ain;
      bus.bin      = vecs[i].bin;
      bus.ALUop    = vecs[i].op;
      #2;
      chk($sformatf("v%0d_sout", i), bus.sout, vecs[i].e_sout);
      chk($sformatf("v%0d_alu", i), bus.alu_out, vecs[i].e_alu);
      chk($sformatf("v%0d_Z", i), {15'd0, bus.Z}, {15'd0, vecs[i].e_z});
      chk($sformatf("v%0d_N", i), {15'd0, bus.N}, {15'd0, vecs[i].e_n});
      chk($sformatf("v%0d_V", i), {15'd0, bus.V}, {15'd0, vecs[i].e_v});
    end

    bus.readnum  = 3'd3;
    bus.write    = 1'b1;
    bus.writenum = 3'd3;
    bus.data_in  = 16'h0042;
    #1;
`ifdef RF_BYPASS_EN
    chk("rf_same_cyc", bus.data_out, 16'h0042);
`else
    chk("rf_same_cyc", bus.data_out, 16'h0000);
`endif
    step();
    bus.write = 1'b0;
    wr(3'd5, 16'hABCD);
    rd("rf_r3", 3'd3, 16'h0042);
    rd("rf_r5", 3'd5, 16'hABCD);

    bus.writenum = 3'd3;
    bus.data_in  = 16'hFFFF;
    step();
    step();
    rd("rf_hold_r3", 3'd3, 16'h0042);
    rd("rf_hold_r5", 3'd5, 16'hABCD);

    wr(3'd0, 16'h1111);
    wr(3'd7, 16'h7777);
    rd("rf_r0", 3'd0, 16'h1111);
    rd("rf_r7", 3'd7, 16'h7777);
    rd("rf_r1", 3'd1, 16'h0000);

`ifdef RF_BYPASS_EN
    bus.readnum  = 3'd2;
    bus.writenum = 3'd2;
    bus.write    = 1'b1;
    bus.data_in  = 16'h5A5A;
    #1;
    chk("byp_r2", bus.data_out, 16'h5A5A);
    step();
    bus.write = 1'b0;
    rd("byp_r2_after", 3'd2, 16'h5A5A);
`endif

    bus.ain   = 16'h0005;
    bus.bin   = 16'h0005;
    bus.ALUop = 2'b01;
    bus.loads = 1'b1;
    step();
    bus.loads = 1'b0;
    chk("st_z1", {13'd0, bus.Z_out, bus.N_out, bus.V_out}, 16'b100);

    bus.ain   = 16'h7FFF;
    bus.bin   = 16'h0001;
    bus.ALUop = 2'b00;
    step();
    step();
    chk("st_hold", {13'd0, bus.Z_out, bus.N_out, bus.V_out}, 16'b100);

    bus.loads    = 1'b1;
    bus.write    = 1'b1;
    bus.writenum = 3'd6;
    bus.data_in  = 16'h6666;
    #1;
    chk("st_pre_edge", {13'd0, bus.Z_out, bus.N_out, bus.V_out}, 16'b100);
    step();
    bus.loads = 1'b0;
    bus.write = 1'b0;
    chk("st_load", {13'd0, bus.Z_out, bus.N_out, bus.V_out}, 16'b011);
    rd("st_wr_r6", 3'd6, 16'h6666);

    bus.readnum = 3'd7;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_r7", bus.data_out, 16'h0000);
    chk("arst_flags", {13'd0, bus.Z_out, bus.N_out, bus.V_out}, 16'b000);
    rd("arst_r6", 3'd6, 16'h0000);
    rd("arst_r0", 3'd0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    rd("post_rst_r3", 3'd3, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
